// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed/unsigned multiply and divide unit.
//
// Multiplication uses one shift-add step per cycle and division uses one
// restoring shift-subtract step per cycle. Both work on operand magnitudes,
// and a final FIX cycle applies sign correction for the signed ops.
// A divide by zero skips the iterations and completes immediately.
//
// Parameters:
//   WIDTH        operand width (even, 4..64)
//   DIVZERO_QUOT quotient (Lo) reported on divide-by-zero
//
// Ports:
//   Clk      clock, rising edge
//   Reset    synchronous active-high reset
//   Start    operation request, accepted only while idle
//   Op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B     multiplicand/dividend, multiplier/divisor
//   Busy     high while iterating (RUN) or sign-correcting (FIX)
//   Done     one-cycle completion pulse
//   DivZero  last completed operation was a divide by zero
//   Hi, Lo   product upper/lower half, or remainder/quotient
module mult_div_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] DIVZERO_QUOT = '1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_zero_q, div_zero_d;

    logic             in_signed;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mult_sum;
    logic [WIDTH:0]   div_shifted;
    logic [WIDTH:0]   div_trial;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0] quot_fixed, rem_fixed;

    // Next-state and datapath. Op[1] selects divide, Op[0] selects unsigned.
    // The accumulator pair {acc_hi, acc_lo} holds the partial product during
    // a multiply (multiplier bits shift out of acc_lo as product bits shift
    // in), and the partial remainder / developing quotient during a divide.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        operand_d  = operand_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        in_signed   = ~Op[0];
        abs_a       = (in_signed && A[WIDTH-1]) ? -A : A;
        abs_b       = (in_signed && B[WIDTH-1]) ? -B : B;
        mult_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, operand_q} : '0);
        div_shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_trial   = div_shifted - {1'b0, operand_q};
        product     = {acc_hi_q, acc_lo_q};
        quot_fixed  = acc_lo_q;
        rem_fixed   = acc_hi_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    op_d = Op;
                    if (Op[1] && B == '0) begin
                        hi_d       = A;
                        lo_d       = DIVZERO_QUOT;
                        div_zero_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        sign_a_d  = in_signed & A[WIDTH-1];
                        sign_b_d  = in_signed & B[WIDTH-1];
                        acc_hi_d  = '0;
                        operand_d = Op[1] ? abs_b : abs_a;
                        acc_lo_d  = Op[1] ? abs_a : abs_b;
                        count_d   = CW'(WIDTH);
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                if (op_q[1]) begin
                    // Restoring step: keep the subtraction only if it did not borrow.
                    // A restored value is below the divisor, so it fits WIDTH bits.
                    if (!div_trial[WIDTH]) begin
                        acc_hi_d = div_trial[WIDTH-1:0];
                    end else begin
                        acc_hi_d = div_shifted[WIDTH-1:0];
                    end
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
                end else begin
                    acc_hi_d = mult_sum[WIDTH:1];
                    acc_lo_d = {mult_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                count_d = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // Quotient sign follows the operand signs; remainder follows the
                // dividend. Most-negative / -1 wraps back to most-negative here.
                if (op_q[1]) begin
                    if (sign_a_q ^ sign_b_q) quot_fixed = -acc_lo_q;
                    if (sign_a_q)            rem_fixed  = -acc_hi_q;
                    hi_d = rem_fixed;
                    lo_d = quot_fixed;
                end else begin
                    if (sign_a_q ^ sign_b_q) product = -{acc_hi_q, acc_lo_q};
                    hi_d = product[2*WIDTH-1:WIDTH];
                    lo_d = product[WIDTH-1:0];
                end
                div_zero_d = 1'b0;
                state_d    = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over everything, including Start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            op_q       <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            operand_q  <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            operand_q  <= operand_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign Busy    = (state_q == RUN) || (state_q == FIX);
    assign Done    = (state_q == DONE);
    assign DivZero = div_zero_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width (even, 4..64).
REQ-002 SHALL have parameter DIVZERO_QUOT, default all ones, Lo value written on divide-by-zero.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports (name, direction, width, meaning):
- Clk  input  1  clock, rising edge
- Reset  input  1  synchronous active-high reset
- Start  input  1  request an operation; sampled only in IDLE
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  input  WIDTH  multiplicand / dividend
- B  input  WIDTH  multiplier / divisor
- Busy  output  1  operation in progress
- Done  output  1  one-cycle completion pulse
- DivZero  output  1  last completed operation was a divide by zero
- Hi  output  WIDTH  product upper half / remainder
- Lo  output  WIDTH  product lower half / quotient

Function
REQ-005 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-006 IDLE with Start=1 SHALL latch A, B and Op, set Busy=1 and go to RUN with iteration counter=WIDTH.
- Exception: divide op with B=0 SHALL go directly to DONE.
REQ-007 Start SHALL be ignored in RUN, FIX and DONE; latched operands SHALL NOT change mid-operation.
REQ-008 RUN SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step on operand magnitudes per cycle.
- Counter decrements each step; RUN→FIX when the counter reaches 0 after WIDTH steps.
REQ-009 FIX SHALL apply sign correction for signed ops, then go to DONE.
REQ-010 DONE SHALL set Done=1 for exactly one cycle, update Hi/Lo, then return to IDLE. Busy SHALL be 1 in RUN and FIX, and 0 in DONE and IDLE.
REQ-011 Latency: Done SHALL be high in the cycle after WIDTH+2 rising edges, counting from the edge that sampled Start (WIDTH+2 cycles total). Divide-by-zero SHALL reach Done after 1 edge.
REQ-012 MULT/MULTU SHALL produce the exact 2*WIDTH product, signed or unsigned: {Hi,Lo}.
REQ-013 DIV SHALL truncate the quotient toward zero; the remainder SHALL take the sign of the dividend. DIVU SHALL be unsigned.
REQ-014 DIV of most-negative by -1 SHALL give Lo=most-negative and Hi=0, with no error flag.
REQ-015 Divide by zero SHALL give Hi=A, Lo=DIVZERO_QUOT and DivZero=1.
REQ-016 DivZero SHALL update only in DONE: 1 for divide-by-zero, 0 for any other completion.
REQ-017 Hi, Lo and DivZero SHALL hold their values between completions. A new Start SHALL NOT disturb them until its own DONE.
REQ-018 Start asserted in the same cycle as Done (state DONE) SHALL be ignored. A Start in the following IDLE cycle SHALL be accepted.

Reset
REQ-019 Reset=1 at a rising edge SHALL force IDLE and set Busy=0, Done=0, DivZero=0, Hi=0, Lo=0, counter=0, in any state.
REQ-020 Reset SHALL abort an operation in progress; no Done SHALL follow for the aborted operation.
REQ-021 Reset SHALL take priority over Start in the same cycle.

Verification (WIDTH=32)
REQ-022 MULT A=0xFFFFFFFD (-3), B=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1, Done exactly 34 cycles after Start, Busy high for 33 cycles.
REQ-023 MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. MULT with the same operands -> Hi=0, Lo=1.
REQ-024 DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU A=100, B=7 -> Lo=14, Hi=2.
REQ-025 DIVU A=100, B=0 -> Done after 1 edge, Hi=100, Lo=0xFFFFFFFF, DivZero=1. A following MULT 2*3 -> DivZero=0, Lo=6, Hi=0.
REQ-026 DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
REQ-027 Reset and Start checks -> required response:
- Start MULT 7*9, Reset pulse at cycle 10 -> Busy=0, Hi=Lo=0, no Done.
- Start pulses while Busy -> no effect on result or latency.
